ram_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares one synchronous single-port RAM between NUM_REQ requesters.
- Each requester presents a read or write command with a req/gnt handshake. The block serialises the commands onto the RAM port and returns read data to the requester that issued the read.
- Sits between the requester agents and the ram instance, driving the RAM's en/we/addr/wdata and sampling its rdata.

---
 rtl/ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and access sequencer that shares one
// synchronous single-port RAM between NUM_REQ requesters.
// Optional build macro RAM_ARB_PRIO_EN: requester 0 gets fixed highest
// priority. The remaining requesters share round-robin among themselves.
//
// Handshake: a requester raises req_i[k] together with we_i/addr_i/wdata_i and
// keeps them stable until the cycle after its one-cycle gnt_o[k] pulse.
// During that following cycle it may drop req or present a new command, which
// then enters arbitration again. A read answers with a one-cycle rvalid_o[k]
// pulse RD_LATENCY+1 cycles after gnt_o[k]. rdata_o is valid during that pulse.
module ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          busy_o,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic [1:0]                    dbg_state_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]      pend;
  logic                    found;
  logic [PW-1:0]           win;
  logic [PW-1:0]           ptr_after;

  // Returns {found, index}: first set bit of p searching upward from ptr with wrap.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] p,
                                          input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          k;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!res[PW] && p[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction

  // Arbitration: pick the next winner and the pointer value that follows it.
  // The requester granted in the current ACCESS cycle still holds req high,
  // so it is masked out of the search.
  always_comb begin
    logic [PW:0] pick;
    pend = req_i;
    if (state_q == ACCESS) pend = req_i & ~gnt_q;
    ptr_after = rr_ptr_q;
`ifdef RAM_ARB_PRIO_EN
    if (pend[0]) begin
      found = 1'b1;
      win   = '0;
    end else begin
      pick  = rr_pick({pend[NUM_REQ-1:1], 1'b0}, rr_ptr_q);
      found = pick[PW];
      win   = pick[PW-1:0];
      if (found) ptr_after = (win == PW'(NUM_REQ-1)) ? '0 : win + PW'(1);
    end
`else
    pick  = rr_pick(pend, rr_ptr_q);
    found = pick[PW];
    win   = pick[PW-1:0];
    if (found) ptr_after = (win == PW'(NUM_REQ-1)) ? '0 : win + PW'(1);
`endif
  end

  // Next-state and next-output logic for the IDLE/ACCESS/RD_WAIT sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = '0;
    en_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE, ACCESS: begin
        if (state_q == ACCESS && !we_q) begin
          // Read issued this cycle: wait for the RAM pipeline to return data.
          cnt_d   = CW'(RD_LATENCY);
          state_d = RD_WAIT;
        end else if (found) begin
          state_d     = ACCESS;
          rr_ptr_d    = ptr_after;
          gnt_d[win]  = 1'b1;
          en_d        = 1'b1;
          we_d        = we_i[win];
          addr_d      = addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
          owner_d     = win;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d           = ram_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update; reset discards any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign ram_en      = en_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a RAM model with RD_LATENCY pipeline,
// a batch driver that predicts grant order from the round-robin rule, and a
// monitor that pops expected grants, RAM writes and read returns.
module tb_ram_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RL = 3;

  typedef struct {
    int id;
    int gap;
  } gnt_exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_i = '0;
  logic [NR-1:0]    we_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR*DW-1:0] wdata_i = '0;
  logic [NR-1:0]    gnt_o;
  logic [NR-1:0]    rvalid_o;
  logic [DW-1:0]    rdata_o;
  logic             busy_o;
  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic [DW-1:0]    ram_rdata;
  logic [1:0]       dbg_state_o;

  ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state_o(dbg_state_o)
  );

  // ---------------- RAM model (environment) ----------------
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        rd_pipe[0] <= ram_mem[ram_addr];
    end
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_rdata = rd_pipe[RL-1];

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             last_gnt_cyc = 0;
  int             last_rd_cyc = 0;
  bit             in_rst = 1'b1;
  int             mdl_ptr = 0;
  logic [DW-1:0]  ref_mem [256];
  gnt_exp_t       exp_gnt_q[$];
  logic [AW+DW-1:0] exp_w_q[$];
  logic [15:0]    exp_rd_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2id(input logic [NR-1:0] v);
    int r = -1;
    for (int k = 0; k < NR; k++) if (v[k]) r = k;
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!in_rst) begin
      if (gnt_o != '0 || ram_en) begin
        chk("gnt_onehot", $countones(gnt_o), 1);
        chk("en_with_gnt", ram_en, 1'b1);
        if (exp_gnt_q.size() == 0) begin
          chk("unexpected_gnt", gnt_o, 0);
        end else begin
          gnt_exp_t e;
          e = exp_gnt_q.pop_front();
          chk("gnt_id", oh2id(gnt_o), e.id);
          if (e.gap != 0) chk("gnt_gap", cyc - last_gnt_cyc, e.gap);
        end
        last_gnt_cyc = cyc;
        if (!ram_we) last_rd_cyc = cyc;
      end
      if (ram_en && ram_we) begin
        if (exp_w_q.size() == 0) chk("unexpected_ram_write", {ram_addr, ram_wdata}, 0);
        else chk("ram_write", {ram_addr, ram_wdata}, exp_w_q.pop_front());
      end
      if (rvalid_o != '0) begin
        chk("rvalid_onehot", $countones(rvalid_o), 1);
        if (exp_rd_q.size() == 0) chk("unexpected_rvalid", rvalid_o, 0);
        else chk("read_return", {8'(oh2id(rvalid_o)), rdata_o}, exp_rd_q.pop_front());
        chk("read_latency", cyc - last_rd_cyc, RL + 1);
      end
    end
  end

  // ---------------- reference model: grant order of a batch ----------------
  // All requesters in m assert together and stay pending until granted, so
  // the grant order is the cyclic order starting at the pointer.
  task automatic predict(input logic [NR-1:0] m, input logic [NR-1:0] w,
                         input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    int order[$];
    int last = -1;
    int gap = 0;
    gnt_exp_t e;
`ifdef RAM_ARB_PRIO_EN
    if (m[0]) order.push_back(0);
`endif
    for (int i = 0; i < NR; i++) begin
      int k = (mdl_ptr + i) % NR;
`ifdef RAM_ARB_PRIO_EN
      if (k == 0) continue;
`endif
      if (m[k]) begin
        order.push_back(k);
        last = k;
      end
    end
    if (last >= 0) mdl_ptr = (last + 1) % NR;
    foreach (order[j]) begin
      int k = order[j];
      logic [AW-1:0] ak = a[k*AW +: AW];
      e.id = k;
      e.gap = gap;
      exp_gnt_q.push_back(e);
      if (w[k]) begin
        exp_w_q.push_back({ak, d[k*DW +: DW]});
        ref_mem[ak] = d[k*DW +: DW];
        gap = 1;
      end else begin
        exp_rd_q.push_back({8'(k), ref_mem[ak]});
        gap = RL + 2;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 300);
    chk("idle_timeout", n < 300, 1'b1);
    repeat (2) @(negedge clk);
    chk("gnt_drain", exp_gnt_q.size(), 0);
    chk("rd_drain", exp_rd_q.size(), 0);
    chk("wr_drain", exp_w_q.size(), 0);
    exp_gnt_q.delete();
    exp_rd_q.delete();
    exp_w_q.delete();
  endtask

  task automatic run_batch(input logic [NR-1:0] m, input logic [NR-1:0] w,
                           input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d);
    logic [NR-1:0] pend = m;
    int n = 0;
    predict(m, w, a, d);
    @(posedge clk); #1;
    req_i = m; we_i = w; addr_i = a; wdata_i = d;
    while (pend != '0 && n < 300) begin
      @(negedge clk);
      pend = pend & ~gnt_o;
      @(posedge clk); #1;
      req_i = pend;
      n++;
    end
    chk("grant_timeout", pend, 0);
    req_i = '0;
    wait_idle();
  endtask

  task automatic wait_gnt(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_o[k] && n < 50);
    chk("wait_gnt", gnt_o[k], 1'b1);
  endtask

  task automatic check_all_zero();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    in_rst = 1'b0;
    mdl_ptr = 0;

    // Single write then read by requester 2.
    a = '0; d = '0;
    a[2*AW +: AW] = 8'h10;
    d[2*DW +: DW] = 8'hA5;
    run_batch(4'b0100, 4'b0100, a, d);
    run_batch(4'b0100, 4'b0000, a, d);

    // Fairness and wrap: 3 then {0,3}.
    for (int k = 0; k < NR; k++) begin
      a[k*AW +: AW] = 8'(8'h20 + k);
      d[k*DW +: DW] = 8'($urandom_range(0, 255));
    end
    run_batch(4'b1000, 4'b1111, a, d);
    run_batch(4'b1001, 4'b1111, a, d);

    // Read blocking: pointer to 1, then read by 1 while 0 writes.
    run_batch(4'b0001, 4'b1111, a, d);
    run_batch(4'b0011, 4'b0001, a, d);

    // Withdrawn request: 2 raises req only while 1's read is in RD_WAIT.
    begin
      gnt_exp_t e;
      e.id = 1; e.gap = 0;
      exp_gnt_q.push_back(e);
      exp_rd_q.push_back({8'd1, ref_mem[8'h21]});
      @(posedge clk); #1;
      req_i = 4'b0010; we_i = 4'b0000;
      wait_gnt(1);
      @(posedge clk); #1;
      a[2*AW +: AW] = 8'h33;
      addr_i = a; we_i = 4'b0100; req_i = 4'b0100;
      @(posedge clk); #1;
      req_i = '0;
      mdl_ptr = 2;
      wait_idle();
    end

    // Reset in the middle of a read by requester 3.
    begin
      gnt_exp_t e;
      e.id = 3; e.gap = 0;
      exp_gnt_q.push_back(e);
      @(posedge clk); #1;
      req_i = 4'b1000; we_i = 4'b0000; addr_i = a;
      wait_gnt(3);
      @(posedge clk); #1;
      req_i = '0;
      @(posedge clk); #2;
      in_rst = 1'b1;
      rst_n = 1'b0;
      #1;
      check_all_zero();
      exp_rd_q.delete();
      exp_gnt_q.delete();
      mdl_ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      in_rst = 1'b0;
      repeat (RL + 4) @(negedge clk);
      chk("no_rvalid_after_reset", rvalid_o, 0);
    end

    // All four write together from pointer 0: back-to-back grants 0,1,2,3.
    for (int k = 0; k < NR; k++) begin
      a[k*AW +: AW] = 8'(8'h40 + k);
      d[k*DW +: DW] = 8'($urandom_range(0, 255));
    end
    run_batch(4'b1111, 4'b1111, a, d);

    // Randomized batches over a small address window so reads hit writes.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < NR; k++) begin
        a[k*AW +: AW] = 8'($urandom_range(0, 15));
        d[k*DW +: DW] = 8'($urandom_range(0, 255));
      end
      run_batch(NR'($urandom_range(1, 15)), NR'($urandom_range(0, 15)), a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
